mem_interface: RTL and testbench

Memory-side stage between the multicycle control FSM and the unified instruction/data memory. It turns the control strobes MemRead, MemWrite, IorD and IRWrite into a held request/acknowledge transaction on a variable-latency memory port. It owns the instruction register (IR), whose output `inst` feeds the control FSM's opcode decode, and the memory data register (MDR). It raises `Stall` so the control FSM holds its current state until the access completes.

---
 rtl/proc_pkg.sv | 22 ++
 rtl/mem_watchdog.sv | 40 ++++
 rtl/mem_interface.sv | 152 +++++++++++++++
 tb/tb_mem_interface.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: word width, memory-stage
// state encoding and the opcodes decoded by the control FSM.
`default_nettype none

package proc_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h1;
  localparam logic [3:0] OP_SW    = 4'h2;
  localparam logic [3:0] OP_BEQ   = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;

endpackage

`default_nettype wire

// File: rtl/mem_watchdog.sv
// Counts REQ cycles of a memory access and flags the cycle in which the
// TIMEOUT-th consecutive REQ cycle is reached.
`default_nettype none

module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of REQ cycles already completed, so the
  // TIMEOUT-th REQ cycle is the one that sees TIMEOUT-1.
  assign expire = enable && (count_q == 8'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_interface.sv
// Memory stage: turns control strobes into a held req/ack access and owns IR/MDR.
// Optional access watchdog is built when MEM_TIMEOUT_EN is defined.
`default_nettype none

module mem_interface
  import proc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [WORD_W-1:0] PC,
  input  logic [WORD_W-1:0] ALUOut,
  input  logic [WORD_W-1:0] WriteData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] MDR,
  output logic              Stall,
  output logic              MemError
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_interface: TIMEOUT must be in 1..255");
  end

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              irw_q, irw_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic [WORD_W-1:0] sel_addr;
  logic              strobe;
  logic              timeout_abort;

  assign strobe   = MemRead | MemWrite;
  assign sel_addr = IorD ? ALUOut : PC;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    irw_d   = irw_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          addr_d  = {sel_addr[WORD_W-1:1], 1'b0};
          wdata_d = WriteData;
          we_d    = MemWrite;
          irw_d   = IRWrite & ~MemWrite;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
            if (irw_q) begin
              ir_d = mem_rdata;
            end
          end
          state_d = S_DONE;
        end else if (timeout_abort) begin
          state_d = S_DONE;
        end
      end
      // Control is still in the stalled state during DONE, so its strobes
      // are stale and must not start a second access.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      irw_q   <= irw_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic wdog_expire;
  logic err_q, err_d;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .CLK    (CLK),
    .Reset  (Reset),
    .clear  (state_q == S_IDLE),
    .enable (state_q == S_REQ),
    .expire (wdog_expire)
  );

  // An ack landing in the expiry cycle still completes the access normally.
  assign timeout_abort = wdog_expire & ~mem_ack;

  always_comb begin
    err_d = err_q | timeout_abort;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign MemError = err_q;
`else
  assign timeout_abort = 1'b0;
  assign MemError      = 1'b0;
`endif

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign inst      = ir_q;
  assign MDR       = mdr_q;
  assign Stall     = ((state_q == S_IDLE) & strobe) | (state_q == S_REQ);

endmodule

`default_nettype wire

// File: tb/tb_mem_interface.sv
// Directed self-checking bench for mem_interface; the timeout scenario is
// exercised only when MEM_TIMEOUT_EN is defined.
`default_nettype none

module tb_mem_interface;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
  logic [15:0] PC = '0, ALUOut = '0, WriteData = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] inst, MDR;
  logic        Stall, MemError;

  int checks = 0;
  int errors = 0;

  int          stall_cnt, req_cnt, we_cnt;
  logic [15:0] first_addr, first_wdata;
  logic        addr_changed, wdata_changed;
  logic [15:0] done_inst, done_mdr;
  logic        done_stall, done_req;

  mem_interface #(.TIMEOUT(4)) dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut),
    .WriteData(WriteData), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .inst(inst), .MDR(MDR), .Stall(Stall),
    .MemError(MemError)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one access with ack in REQ cycle k and records what was observed.
  task automatic run_access(input logic rd, input logic wr, input logic iord,
                            input logic irw, input logic [15:0] pc,
                            input logic [15:0] alu, input logic [15:0] wd,
                            input int k, input logic [15:0] rdata);
    MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
    PC = pc; ALUOut = alu; WriteData = wd;
    stall_cnt = 0; req_cnt = 0; we_cnt = 0;
    addr_changed = 1'b0; wdata_changed = 1'b0;
    first_addr = '0; first_wdata = '0;
    for (int c = 0; c <= k + 1; c++) begin
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? rdata : 16'h0BAD;
      #1;
      if (Stall) stall_cnt++;
      if (mem_req) begin
        if (req_cnt == 0) begin
          first_addr = mem_addr; first_wdata = mem_wdata;
        end else begin
          if (mem_addr !== first_addr) addr_changed = 1'b1;
          if (mem_wdata !== first_wdata) wdata_changed = 1'b1;
        end
        req_cnt++;
        if (mem_we) we_cnt++;
      end
      if (c == k + 1) begin
        done_inst = inst; done_mdr = MDR; done_stall = Stall; done_req = mem_req;
      end
      tick();
    end
    mem_ack = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    #1;
    checks++; if (inst !== 16'h0) begin errors++; $display("FAIL reset_inst: got %h want 0000", inst); end
    checks++; if (MDR !== 16'h0) begin errors++; $display("FAIL reset_mdr: got %h want 0000", MDR); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_req_we: got %b%b want 00", mem_req, mem_we); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h %h want 0000 0000", mem_addr, mem_wdata); end
    checks++; if (Stall !== 1'b0 || MemError !== 1'b0) begin errors++; $display("FAIL reset_stall_err: got %b%b want 00", Stall, MemError); end
  endtask

  task automatic test_read_ir();
    run_access(1, 0, 0, 1, 16'h0013, 16'h7777, 16'h0, 1, 16'hA5C8);
    checks++; if (first_addr !== 16'h0012) begin errors++; $display("FAIL rd_addr: got %h want 0012", first_addr); end
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL rd_stall_cycles: got %0d want 2", stall_cnt); end
    checks++; if (req_cnt !== 1 || we_cnt !== 0) begin errors++; $display("FAIL rd_req_we: got %0d/%0d want 1/0", req_cnt, we_cnt); end
    checks++; if (done_inst !== 16'hA5C8 || done_mdr !== 16'hA5C8) begin errors++; $display("FAIL rd_ir_mdr: got %h %h want a5c8 a5c8", done_inst, done_mdr); end
    checks++; if (done_req !== 1'b0 || done_stall !== 1'b0) begin errors++; $display("FAIL rd_done: got req=%b stall=%b want 0 0", done_req, done_stall); end
  endtask

  task automatic test_write();
    run_access(0, 1, 1, 0, 16'h0002, 16'h0040, 16'h1234, 4, 16'hDEAD);
    checks++; if (req_cnt !== 4 || we_cnt !== 4) begin errors++; $display("FAIL wr_req_we_cycles: got %0d/%0d want 4/4", req_cnt, we_cnt); end
    checks++; if (first_addr !== 16'h0040 || addr_changed) begin errors++; $display("FAIL wr_addr: got %h changed=%b want 0040 0", first_addr, addr_changed); end
    checks++; if (first_wdata !== 16'h1234 || wdata_changed) begin errors++; $display("FAIL wr_wdata: got %h changed=%b want 1234 0", first_wdata, wdata_changed); end
    checks++; if (stall_cnt !== 5) begin errors++; $display("FAIL wr_stall_cycles: got %0d want 5", stall_cnt); end
    checks++; if (done_inst !== 16'hA5C8 || done_mdr !== 16'hA5C8) begin errors++; $display("FAIL wr_ir_mdr_hold: got %h %h want a5c8 a5c8", done_inst, done_mdr); end
    checks++; if (MemError !== 1'b0) begin errors++; $display("FAIL wr_no_error: got %b want 0", MemError); end
  endtask

  task automatic test_read_mdr_only();
    run_access(1, 0, 1, 0, 16'h0000, 16'h0041, 16'h0, 2, 16'h00FF);
    checks++; if (first_addr !== 16'h0040) begin errors++; $display("FAIL mdr_addr: got %h want 0040", first_addr); end
    checks++; if (done_mdr !== 16'h00FF) begin errors++; $display("FAIL mdr_value: got %h want 00ff", done_mdr); end
    checks++; if (done_inst !== 16'hA5C8) begin errors++; $display("FAIL mdr_ir_hold: got %h want a5c8", done_inst); end
  endtask

  task automatic test_both_strobes();
    run_access(1, 1, 0, 1, 16'h0100, 16'h0, 16'hBEEF, 1, 16'h1111);
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL both_we: got %0d want 1", we_cnt); end
    checks++; if (first_addr !== 16'h0100 || first_wdata !== 16'hBEEF) begin errors++; $display("FAIL both_addr_data: got %h %h want 0100 beef", first_addr, first_wdata); end
    checks++; if (done_mdr !== 16'h00FF || done_inst !== 16'hA5C8) begin errors++; $display("FAIL both_no_capture: got %h %h want 00ff a5c8", done_mdr, done_inst); end
  endtask

  task automatic test_reset_mid_access();
    MemRead = 1'b1; IRWrite = 1'b1; IorD = 1'b0; PC = 16'h0002;
    tick();
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_in_req: got %b want 1", mem_req); end
    Reset = 1'b1; MemRead = 1'b0; IRWrite = 1'b0;
    tick();
    Reset = 1'b0;
    checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL mid_abort: got req=%b stall=%b want 0 0", mem_req, Stall); end
    checks++; if (inst !== 16'h0 || MDR !== 16'h0) begin errors++; $display("FAIL mid_clear_regs: got %h %h want 0000 0000", inst, MDR); end
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    checks++; if (inst !== 16'h0 || MDR !== 16'h0 || mem_req !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL stray_ack: got inst=%h mdr=%h req=%b stall=%b want 0000 0000 0 0", inst, MDR, mem_req, Stall);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    run_access(1, 0, 0, 1, 16'h0010, 16'h0, 16'h0, 1, 16'h5A5A);
    MemRead = 1'b1; IRWrite = 1'b1; PC = 16'h0020;
    tick();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", n); end
    checks++; if (MemError !== 1'b1) begin errors++; $display("FAIL to_error_set: got %b want 1", MemError); end
    checks++; if (inst !== 16'h5A5A || MDR !== 16'h5A5A) begin errors++; $display("FAIL to_regs_hold: got %h %h want 5a5a 5a5a", inst, MDR); end
    MemRead = 1'b0; IRWrite = 1'b0;
    tick();
    run_access(1, 0, 0, 1, 16'h0030, 16'h0, 16'h0, 2, 16'h3C3C);
    checks++; if (done_inst !== 16'h3C3C || MemError !== 1'b1) begin errors++; $display("FAIL to_sticky: got inst=%h err=%b want 3c3c 1", done_inst, MemError); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (MemError !== 1'b0) begin errors++; $display("FAIL to_reset_clear: got %b want 0", MemError); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_ir();
    test_write();
    test_read_mdr_only();
    test_both_strobes();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
